// File: rtl/uart_cmd_decoder_pkg.sv
// rtl/uart_cmd_decoder_pkg.sv - shared encodings for the UART command decoder
// Purpose: FSM state encoding, error codes, ctrl-byte bit positions and the
//          default command codes used by uart_cmd_decoder.
// Ports:   none (package).
package uart_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_TAIL    = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [2:0] ERR_CHECKSUM    = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd2;
  localparam logic [2:0] ERR_UNKNOWN_CMD = 3'd3;
  localparam logic [2:0] ERR_BAD_CHANNEL = 3'd4;

  // DATA packet ctrl byte layout; bit 1 is reserved and ignored.
  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_CH_LSB = 4;
  localparam int CTRL_CH_W   = 4;

  localparam logic [7:0] DEF_CMD_FREQ    = 8'h0A;
  localparam logic [7:0] DEF_CMD_DATA    = 8'h0B;
  localparam logic [7:0] DEF_CMD_STOPALL = 8'h0C;

endpackage

// File: rtl/uart_cmd_decoder_cmd_timeout_counter.sv
// rtl/uart_cmd_decoder_cmd_timeout_counter.sv - inter-byte timeout counter
// Purpose: counts idle cycles while a packet is in progress and flags expiry.
// Ports:   clk      - system clock
//          rst_n    - synchronous active-low reset
//          clear    - restart the count (byte strobe, or decoder idle)
//          enable   - count while a packet is open
//          expired  - combinational flag, count reached TIMEOUT_CYC with no clear
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  // A strobe (clear) in the expiry cycle wins: the byte is taken instead.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte stream to validated command/config outputs
// Purpose: parses FREQ / DATA / STOPALL packets, validates XOR checksum,
//          inter-byte timeout and channel range, and updates the registered
//          configuration outputs only for accepted packets.
// Ports:   clk_i, rst_ni          - clock, synchronous active-low reset
//          data_i, rx_done_tick_i - received byte and its one-cycle strobe
//          output_pattern_o, freq_pattern_o, slow_period_o, fast_period_o,
//          sel_out_o, mode_o, start_o, stop_o - configuration outputs
//          stop_all_tick_o, done_tick_o, err_tick_o - one-cycle pulses
//          cmd_o, err_code_o      - last accepted command, last error code
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int         DATA_BIT      = 32,
  parameter int         UART_DATA_BIT = 8,
  parameter int         CHAN_NUM      = 16,
  parameter int         TIMEOUT_CYC   = 5000,
  parameter logic [7:0] CMD_FREQ      = DEF_CMD_FREQ,
  parameter logic [7:0] CMD_DATA      = DEF_CMD_DATA,
  parameter logic [7:0] CMD_STOPALL   = DEF_CMD_STOPALL
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [UART_DATA_BIT-1:0] data_i,
  input  logic                     rx_done_tick_i,
  output logic [DATA_BIT-1:0]      output_pattern_o,
  output logic [DATA_BIT-1:0]      freq_pattern_o,
  output logic [7:0]               slow_period_o,
  output logic [7:0]               fast_period_o,
  output logic [3:0]               sel_out_o,
  output logic                     mode_o,
  output logic                     start_o,
  output logic                     stop_o,
  output logic                     stop_all_tick_o,
  output logic [7:0]               cmd_o,
  output logic                     done_tick_o,
  output logic                     err_tick_o,
  output logic [2:0]               err_code_o
);

  localparam int PAT_BYTES = DATA_BIT / 8;
  localparam int PCNT_W    = $clog2(PAT_BYTES + 1);
  localparam logic [PCNT_W-1:0] PAT_LAST  = PCNT_W'(PAT_BYTES - 1);
  localparam logic [4:0]        CHAN_LIM  = 5'(CHAN_NUM);

  state_t state, state_next;

  logic [7:0]          cmd_q;
  logic [7:0]          xor_q;
  logic [PCNT_W-1:0]   byte_cnt;
  logic [DATA_BIT-1:0] pat_sr;
  logic [DATA_BIT-1:0] pat_shifted;
  logic [7:0]          tail0;
  logic [7:0]          tail1;

  logic       load_cmd, shift_pat, load_tail, accept, reject;
  logic [2:0] code_next;
  logic       expired;
  logic [3:0] ctrl_ch;

  assign ctrl_ch = tail0[CTRL_CH_LSB +: CTRL_CH_W];

  cmd_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (rx_done_tick_i || state == ST_IDLE),
    .enable (state != ST_IDLE),
    .expired(expired)
  );

  // First pattern byte ends up in [7:0]: new bytes enter at the top.
  always_comb begin
    pat_shifted = pat_sr >> UART_DATA_BIT;
    pat_shifted[DATA_BIT-1 -: UART_DATA_BIT] = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_cmd   = 1'b0;
    shift_pat  = 1'b0;
    load_tail  = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    code_next  = err_code_o;
    case (state)
      ST_IDLE: begin
        if (rx_done_tick_i) begin
          if (data_i == CMD_FREQ || data_i == CMD_DATA) begin
            load_cmd   = 1'b1;
            state_next = ST_PATTERN;
          end else if (data_i == CMD_STOPALL) begin
            load_cmd   = 1'b1;
            state_next = ST_CHECK;
          end else begin
            reject    = 1'b1;
            code_next = ERR_UNKNOWN_CMD;
          end
        end
      end
      ST_PATTERN: begin
        if (rx_done_tick_i) begin
          shift_pat = 1'b1;
          if (byte_cnt == PAT_LAST) state_next = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (rx_done_tick_i) begin
          load_tail = 1'b1;
          if (cmd_q == CMD_DATA || byte_cnt == PCNT_W'(1)) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rx_done_tick_i) begin
          state_next = ST_IDLE;
          if (data_i != xor_q) begin
            reject    = 1'b1;
            code_next = ERR_CHECKSUM;
          end else if (cmd_q == CMD_DATA && {1'b0, ctrl_ch} >= CHAN_LIM) begin
            reject    = 1'b1;
            code_next = ERR_BAD_CHANNEL;
          end else begin
            accept = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // expired is never set together with a strobe, so this cannot collide.
    if (expired) begin
      state_next = ST_IDLE;
      reject     = 1'b1;
      code_next  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmd_q            <= '0;
      xor_q            <= '0;
      byte_cnt         <= '0;
      pat_sr           <= '0;
      tail0            <= '0;
      tail1            <= '0;
      output_pattern_o <= '0;
      freq_pattern_o   <= '0;
      slow_period_o    <= '0;
      fast_period_o    <= '0;
      sel_out_o        <= '0;
      mode_o           <= 1'b0;
      start_o          <= 1'b0;
      stop_o           <= 1'b0;
      stop_all_tick_o  <= 1'b0;
      cmd_o            <= '0;
      done_tick_o      <= 1'b0;
      err_tick_o       <= 1'b0;
      err_code_o       <= '0;
    end else begin
      done_tick_o     <= accept;
      err_tick_o      <= reject;
      stop_all_tick_o <= accept && (cmd_q == CMD_STOPALL);
      if (reject) err_code_o <= code_next;

      // The checksum covers the command byte, so the running XOR starts from it.
      if (load_cmd) begin
        cmd_q    <= data_i;
        xor_q    <= data_i;
        byte_cnt <= '0;
      end
      if (shift_pat) begin
        pat_sr   <= pat_shifted;
        xor_q    <= xor_q ^ data_i;
        byte_cnt <= (byte_cnt == PAT_LAST) ? '0 : byte_cnt + 1'b1;
      end
      if (load_tail) begin
        if (byte_cnt == '0) tail0 <= data_i;
        else                tail1 <= data_i;
        xor_q    <= xor_q ^ data_i;
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (accept) begin
        cmd_o <= cmd_q;
        if (cmd_q == CMD_FREQ) begin
          freq_pattern_o <= pat_sr;
          slow_period_o  <= tail0;
          fast_period_o  <= tail1;
        end else if (cmd_q == CMD_DATA) begin
          output_pattern_o <= pat_sr;
          sel_out_o        <= ctrl_ch;
          stop_o           <= tail0[CTRL_STOP];
          mode_o           <= tail0[CTRL_MODE];
          start_o          <= tail0[CTRL_START];
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        strobe = 1'b0;
  logic [31:0] output_pattern, freq_pattern;
  logic [7:0]  slow_period, fast_period, cmd;
  logic [3:0]  sel_out;
  logic        mode, start, stop, stop_all_tick, done_tick, err_tick;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .CHAN_NUM   (8),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .data_i          (data),
    .rx_done_tick_i  (strobe),
    .output_pattern_o(output_pattern),
    .freq_pattern_o  (freq_pattern),
    .slow_period_o   (slow_period),
    .fast_period_o   (fast_period),
    .sel_out_o       (sel_out),
    .mode_o          (mode),
    .start_o         (start),
    .stop_o          (stop),
    .stop_all_tick_o (stop_all_tick),
    .cmd_o           (cmd),
    .done_tick_o     (done_tick),
    .err_tick_o      (err_tick),
    .err_code_o      (err_code)
  );

  int vec_cnt = 0;
  int miscompares = 0;
  int done_cnt = 0, err_cnt = 0, sa_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    if (done_tick) done_cnt++;
    if (err_tick) err_cnt++;
    if (stop_all_tick) sa_cnt++;
    if (done_tick && err_tick) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pkt[$];
  logic       last_done, last_err, last_sa;
  int         d0, e0, s0;

  // Strobe for one cycle; ticks are sampled one clock after the strobe edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data   = b;
    strobe = 1'b1;
    @(negedge clk);
    strobe    = 1'b0;
    last_done = done_tick;
    last_err  = err_tick;
    last_sa   = stop_all_tick;
    @(negedge clk);
  endtask

  task automatic send_pkt();
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = sa_cnt;
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check_val("rst_out_pat", output_pattern, 32'h0);
    check_val("rst_freq_pat", freq_pattern, 32'h0);
    check_val("rst_misc", {slow_period, fast_period, cmd, sel_out, mode, start, stop},
              32'h0);
    check_val("rst_ticks", {stop_all_tick, done_tick, err_tick, err_code}, 32'h0);
    rst_ni = 1'b1;

    // FREQ accept
    pkt = '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h14, 8'h05, 8'h5F};
    send_pkt();
    check_val("freq_done_lat", {31'd0, last_done}, 32'd1);
    check_val("freq_pat", freq_pattern, 32'h44332211);
    check_val("freq_slow_fast", {slow_period, fast_period}, 32'h1405);
    check_val("freq_cmd", cmd, 32'h0A);
    check_val("freq_data_hold", output_pattern, 32'h0);
    check_val("freq_done_once", done_cnt - d0, 32'd1);

    // DATA accept
    pkt = '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h01, 8'h0A};
    send_pkt();
    check_val("data_done_lat", {31'd0, last_done}, 32'd1);
    check_val("data_pat", output_pattern, 32'h55555555);
    check_val("data_ctrl", {sel_out, stop, mode, start}, {25'd0, 4'd0, 3'b001});
    check_val("data_freq_hold", freq_pattern, 32'h44332211);
    check_val("data_cmd", cmd, 32'h0B);

    // Bad checksum, then a valid FREQ
    pkt = '{8'h0A, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h20, 8'h30, 8'h00};
    send_pkt();
    check_val("csum_err_lat", {31'd0, last_err}, 32'd1);
    check_val("csum_code", err_code, 32'd1);
    check_val("csum_no_done", done_cnt - d0, 32'd0);
    check_val("csum_freq_hold", freq_pattern, 32'h44332211);
    check_val("csum_cmd_hold", cmd, 32'h0B);
    pkt = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h09, 8'h00};
    send_pkt();
    check_val("freq2_done", done_cnt - d0, 32'd1);
    check_val("freq2_pat", freq_pattern, 32'h04030201);
    check_val("freq2_slow_fast", {slow_period, fast_period}, 32'h0709);
    check_val("freq2_code_hold", err_code, 32'd1);

    // Channel range with CHAN_NUM = 8
    pkt = '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'hF1, 8'hFA};
    send_pkt();
    check_val("chan_err_lat", {31'd0, last_err}, 32'd1);
    check_val("chan_code", err_code, 32'd4);
    check_val("chan_no_done", done_cnt - d0, 32'd0);
    pkt = '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h71, 8'h7A};
    send_pkt();
    check_val("chan7_done", done_cnt - d0, 32'd1);
    check_val("chan7_sel", sel_out, 32'd7);
    pkt = '{8'h0B, 8'h78, 8'h56, 8'h34, 8'h12, 8'h2C, 8'h2F};
    send_pkt();
    check_val("data2_pat", output_pattern, 32'h12345678);
    check_val("data2_ctrl", {sel_out, stop, mode, start}, {25'd0, 4'd2, 3'b110});

    // Timeout after 0A 11
    pkt = '{8'h0A, 8'h11};
    send_pkt();
    cyc = 0;
    while (!err_tick && cyc < TO + 20) begin
      @(negedge clk);
      cyc++;
    end
    check_val("to_latency", cyc, TO);
    check_val("to_code", err_code, 32'd2);
    check_val("to_freq_hold", freq_pattern, 32'h04030201);
    pkt = '{8'h0B, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h4E};
    send_pkt();
    check_val("to_next_done", done_cnt - d0, 32'd1);
    check_val("to_next_pat", output_pattern, 32'h44332211);

    // Unknown command
    pkt = '{8'h7E};
    send_pkt();
    check_val("unk_err_lat", {31'd0, last_err}, 32'd1);
    check_val("unk_code", err_code, 32'd3);

    // STOPALL
    pkt = '{8'h0C, 8'h0C};
    send_pkt();
    check_val("sa_ticks_lat", {30'd0, last_done, last_sa}, 32'b11);
    check_val("sa_counts", {(done_cnt - d0), (sa_cnt - s0)}, {32'd1, 32'd1});
    check_val("sa_cmd", cmd, 32'h0C);
    check_val("sa_data_hold", output_pattern, 32'h44332211);

    // Reset mid DATA packet
    pkt = '{8'h0B, 8'h55, 8'h55};
    send_pkt();
    @(negedge clk);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    check_val("mid_rst_pats", output_pattern | freq_pattern, 32'h0);
    check_val("mid_rst_misc", {slow_period, fast_period, cmd, sel_out, mode, start, stop},
              32'h0);
    check_val("mid_rst_code", err_code, 32'h0);
    rst_ni = 1'b1;
    pkt = '{8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h01, 8'h0A};
    send_pkt();
    check_val("post_rst_done", done_cnt - d0, 32'd1);
    check_val("post_rst_pat", output_pattern, 32'h55555555);

    check_val("done_err_overlap", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
